// File: rtl/multicycle_ctrl_if.sv
// Control-side bundle of the multicycle sequencer: decoded opcode, branch result,
// memory handshakes, datapath strobes/selects and debug state.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       br_taken;
    logic       im_ack;
    logic       dm_ack;
    logic       im_req;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       dm_req;
    logic       dm_we;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       illegal;
    logic [2:0] state;

    modport master (
        input  opcode, br_taken, im_ack, dm_ack,
        output im_req, ir_we, pc_we, pc_sel, dm_req, dm_we, rf_we, wb_sel, illegal, state
    );

    modport slave (
        output opcode, br_taken, im_ack, dm_ack,
        input  im_req, ir_we, pc_we, pc_sel, dm_req, dm_we, rf_we, wb_sel, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM for the non-pipelined RV32I core, one architectural step per state.
// Define MEM_TIMEOUT_EN to bound im_ack/dm_ack waits with a trap after TIMEOUT_CYCLES.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_ctrl_if.master      bus
);

    typedef enum logic [2:0] {
        StBoot   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       supported;
    logic       is_store;
    logic       im_req, ir_we, pc_we, dm_req, dm_we, rf_we;
    logic [1:0] pc_sel, wb_sel;
    logic       timeout;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        unique case (bus.opcode)
            OpLui, OpAuipc, OpJal, OpJalr, OpBranch,
            OpLoad, OpStore, OpImm, OpReg: supported = 1'b1;
            default:                       supported = 1'b0;
        endcase
    end

    assign is_store = (bus.opcode == OpStore);

    always_comb begin
        // Counter width must be able to hold the timeout value.
        assert (TIMEOUT_CYCLES < (1 << CNT_W));
        state_d   = state_q;
        illegal_d = illegal_q;
        im_req    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        timeout   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        // Zero outside a wait, so the count starts clean on every FETCH/MEM entry.
        cnt_d = '0;
        if ((state_q == StFetch && !bus.im_ack) || (state_q == StMem && !bus.dm_ack)) begin
            cnt_d   = cnt_q + 1'b1;
            timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        end
`endif

        unique case (state_q)
            StBoot: state_d = StFetch;
            StFetch: begin
                im_req = 1'b1;
                if (bus.im_ack) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    illegal_d = 1'b1;
                    state_d   = StTrap;
                end
            end
            StDecode: begin
                if (supported) begin
                    state_d = StExec;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StTrap;
                end
            end
            StExec: begin
                if (bus.opcode == OpLoad || is_store) begin
                    state_d = StMem;
                end else if (bus.opcode == OpBranch) begin
                    pc_we   = 1'b1;
                    pc_sel  = bus.br_taken ? 2'd1 : 2'd0;
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dm_req = 1'b1;
                dm_we  = is_store;
                if (bus.dm_ack) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    illegal_d = 1'b1;
                    state_d   = StTrap;
                end
            end
            StWb: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                if (bus.opcode == OpLoad) begin
                    wb_sel = 2'd1;
                end else if (bus.opcode == OpJal || bus.opcode == OpJalr) begin
                    wb_sel = 2'd2;
                end
                if (bus.opcode == OpJal) begin
                    pc_sel = 2'd1;
                end else if (bus.opcode == OpJalr) begin
                    pc_sel = 2'd2;
                end
                state_d = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StBoot;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.im_req  = im_req;
    assign bus.ir_we   = ir_we;
    assign bus.pc_we   = pc_we;
    assign bus.pc_sel  = pc_sel;
    assign bus.dm_req  = dm_req;
    assign bus.dm_we   = dm_we;
    assign bus.rf_we   = rf_we;
    assign bus.wb_sel  = wb_sel;
    assign bus.illegal = illegal_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors go through a
// scoreboard queue and are checked with immediate assertions at the falling edge.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       im_req;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       dm_req;
        logic       dm_we;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] st, input logic im, input logic ir,
                                input logic pcw, input logic [1:0] pcs, input logic dm,
                                input logic dmw, input logic rf, input logic [1:0] wbs,
                                input logic ill);
        exp_t e;
        e = '{st: st, im_req: im, ir_we: ir, pc_we: pcw, pc_sel: pcs, dm_req: dm,
              dm_we: dmw, rf_we: rf, wb_sel: wbs, ill: ill};
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = '{st: bus.state, im_req: bus.im_req, ir_we: bus.ir_we, pc_we: bus.pc_we,
              pc_sel: bus.pc_sel, dm_req: bus.dm_req, dm_we: bus.dm_we, rf_we: bus.rf_we,
              wb_sel: bus.wb_sel, ill: bus.illegal};
        return o;
    endfunction

    task automatic drive(input logic [6:0] op, input logic br, input logic ia, input logic da);
        bus.opcode   = op;
        bus.br_taken = br;
        bus.im_ack   = ia;
        bus.dm_ack   = da;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        exp_t o;
        e = sb_q.pop_front();
        o = observed();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Push the expectation, check it mid-cycle, then advance to just after the next edge.
    task automatic cyc(input string tag, input exp_t e);
        sb_q.push_back(e);
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_boot();
        rst = 1'b0;
        #1;
        sb_q.push_back(mk(3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        compare("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("boot", mk(3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
    endtask

    initial begin
        drive(7'b0010011, 1'b0, 1'b1, 1'b0);
        // Reset held for three cycles, then an OP-IMM instruction.
        for (int i = 0; i < 3; i++) cyc("in_reset", mk(3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        rst = 1'b1;
        cyc("boot_c0",   mk(3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("opimm_f",   mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("opimm_d",   mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("opimm_e",   mk(3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("opimm_wb",  mk(3'd5, 0, 0, 1, 2'd0, 0, 0, 1, 2'd0, 0));

        // Taken branch.
        drive(7'b1100011, 1'b1, 1'b1, 1'b0);
        cyc("brt_f",     mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("brt_d",     mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("brt_e",     mk(3'd3, 0, 0, 1, 2'd1, 0, 0, 0, 2'd0, 0));
        // Not-taken branch with a two-cycle fetch wait.
        drive(7'b1100011, 1'b0, 1'b0, 1'b0);
        cyc("brn_w0",    mk(3'd1, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("brn_w1",    mk(3'd1, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        bus.im_ack = 1'b1;
        cyc("brn_f",     mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("brn_d",     mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("brn_e",     mk(3'd3, 0, 0, 1, 2'd0, 0, 0, 0, 2'd0, 0));

        // Load with three wait states; spurious dm_ack before MEM, spurious im_ack in MEM.
        drive(7'b0000011, 1'b0, 1'b1, 1'b1);
        cyc("ld_f",      mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("ld_d",      mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("ld_e",      mk(3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        bus.dm_ack = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ld_mwait", mk(3'd4, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 0));
        bus.dm_ack = 1'b1;
        cyc("ld_mack",   mk(3'd4, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 0));
        cyc("ld_wb",     mk(3'd5, 0, 0, 1, 2'd0, 0, 0, 1, 2'd1, 0));

        // Store, zero-wait.
        drive(7'b0100011, 1'b0, 1'b1, 1'b1);
        cyc("st_f",      mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("st_d",      mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("st_e",      mk(3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("st_m",      mk(3'd4, 0, 0, 1, 2'd0, 1, 1, 0, 2'd0, 0));

        // JALR then JAL.
        drive(7'b1100111, 1'b0, 1'b1, 1'b0);
        cyc("jalr_f",    mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("jalr_d",    mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("jalr_e",    mk(3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("jalr_wb",   mk(3'd5, 0, 0, 1, 2'd2, 0, 0, 1, 2'd2, 0));
        drive(7'b1101111, 1'b0, 1'b1, 1'b0);
        cyc("jal_f",     mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("jal_d",     mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("jal_e",     mk(3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("jal_wb",    mk(3'd5, 0, 0, 1, 2'd1, 0, 0, 1, 2'd2, 0));

        // Reset mid-load: request drops in the same cycle.
        drive(7'b0000011, 1'b0, 1'b1, 1'b0);
        cyc("rml_f",     mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("rml_d",     mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("rml_e",     mk(3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("rml_m",     mk(3'd4, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 0));
        reset_boot();

        // Illegal opcode: sticky trap, cleared only by reset.
        drive(7'b1111111, 1'b1, 1'b1, 1'b0);
        cyc("ill_f",     mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("ill_d",     mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        for (int i = 0; i < 20; i++) begin
            bus.dm_ack = 1'(i);
            cyc("ill_trap", mk(3'd6, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1));
        end
        drive(7'b0010011, 1'b0, 1'b1, 1'b0);
        reset_boot();
        cyc("post_rst_f", mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));

`ifdef MEM_TIMEOUT_EN
        // Fetch timeout after four unacked cycles.
        reset_boot();
        bus.im_ack = 1'b0;
        for (int i = 0; i < 4; i++) cyc("to_wait", mk(3'd1, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("to_trap",   mk(3'd6, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1));
        // Ack on the fourth cycle wins over the timeout.
        reset_boot();
        for (int i = 0; i < 3; i++) cyc("ta_wait", mk(3'd1, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        bus.im_ack = 1'b1;
        cyc("ta_ack",    mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("ta_dec",    mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
`else
        // Without the timeout feature a long fetch wait never traps.
        reset_boot();
        bus.im_ack = 1'b0;
        for (int i = 0; i < 8; i++) cyc("long_wait", mk(3'd1, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        bus.im_ack = 1'b1;
        cyc("long_ack",  mk(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0));
        cyc("long_dec",  mk(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main sequencing FSM for the non-pipelined RV32I core.
- Drives the instruction-memory and data-memory request handshakes.
- Issues the IR, PC and register-file write strobes and the PC/writeback mux selects, one architectural step per state.
- Sits beside the hazard/branch detection logic.
- Consumes the decoded opcode and the ALU branch-compare result.

Parameters:
- TIMEOUT_CYCLES, 255: max wait cycles for im_ack/dm_ack. Used only when MEM_TIMEOUT_EN is defined.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] from the IR. Stable from DECODE until FETCH is re-entered.
- br_taken  in  1  branch-compare result from the ALU; valid in EXEC.
- im_ack  in  1  instruction memory has data this cycle.
- dm_ack  in  1  data memory has completed the access this cycle.
- im_req  out  1  instruction fetch request.
- ir_we  out  1  IR load strobe.
- pc_we  out  1  PC update strobe.
- pc_sel  out  2  next-PC source: 0 = PC+4, 1 = PC+imm (branch/JAL), 2 = (rs1+imm)&~1 (JALR).
- dm_req  out  1  data memory request.
- dm_we  out  1  data memory write (store).
- rf_we  out  1  register-file write strobe.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = load data, 2 = PC+4.
- illegal  out  1  sticky unsupported-opcode flag.
- state  out  3  current state encoding, for debug/bench.

Behaviour:
- States and encodings: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset (rst=0, asynchronous): state=BOOT, illegal=0, wait counter=0. All outputs are 0 while in BOOT.
- BOOT -> FETCH unconditionally on the first clock edge after reset release.
- FETCH:
  - im_req=1 every cycle in FETCH.
  - On im_ack=1 (ack may arrive in the same cycle as the request): ir_we=1, go to DECODE.
  - Otherwise remain in FETCH. im_req stays high until acked.
- DECODE:
  - Supported opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Supported opcode: go to EXEC.
  - Any other opcode: set illegal=1, go to TRAP.
- EXEC:
  - LOAD/STORE: go to MEM.
  - BRANCH: pc_we=1, pc_sel = br_taken ? 1 : 0, go to FETCH. No WB state.
  - All other opcodes: go to WB.
- MEM:
  - dm_req=1 every cycle in MEM; dm_we=1 iff STORE.
  - On dm_ack: STORE gives pc_we=1, pc_sel=0, go to FETCH; LOAD goes to WB.
  - Without dm_ack: remain in MEM.
- WB:
  - rf_we=1 and pc_we=1, then go to FETCH.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
- TRAP: all strobes 0, illegal held at 1. Exits only via reset.
- Output timing: outputs are combinational from state, opcode, br_taken and the acks. ir_we, pc_we and rf_we are never high outside the cycles listed above.
- Exclusivity: at most one of im_req and dm_req is high in any cycle.
- Latency with zero-wait memory: BRANCH 3 cycles, ALU/LUI/AUIPC/JAL/JALR 4, STORE 4, LOAD 5.
- Spurious acks: im_ack outside FETCH and dm_ack outside MEM are ignored.
- Reset mid-operation: async return to BOOT. Any pending request drops in the same cycle; no strobe is issued.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A CNT_W-bit counter clears on entry to FETCH or MEM and increments each cycle spent waiting for an ack.
  - Timeout fires when the counter reaches TIMEOUT_CYCLES without an ack. On that cycle: illegal=1, go to TRAP, drop the request.
  - An ack arriving in that same cycle wins; no trap.
- Undefined: no counter. Waits are unbounded.

Test Plan:
- Reset and boot: hold rst=0 for 3 cycles, release, opcode=0010011, im_ack tied 1.
  - Expect: state 0 -> 1 -> 2 -> 3 -> 5 -> 1; rf_we=1 and pc_we=1 only in cycle 4 after release; wb_sel=0, pc_sel=0.
- Branch: BRANCH with br_taken=1, then again with br_taken=0.
  - Expect: in EXEC, pc_we=1 with pc_sel=1 (taken) and pc_sel=0 (not taken); FETCH re-entered next cycle; rf_we never asserted.
- Load with wait states: LOAD, dm_ack delayed 3 cycles.
  - Expect: dm_req=1, dm_we=0 for 4 cycles, then WB with wb_sel=1, rf_we=1; total 8 cycles.
- JALR: opcode 1100111.
  - Expect: WB with wb_sel=2, pc_sel=2, rf_we=1, pc_we=1.
- Illegal opcode: opcode 1111111.
  - Expect: illegal=1 the cycle after DECODE; state=6 held for 20 cycles with no strobes; rst pulse clears to BOOT with illegal=0.
- Timeout (MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4): im_ack held 0.
  - Expect: TRAP after the 4th wait cycle, im_req drops, illegal=1.
  - Repeat with the ack arriving on that 4th cycle: expect a normal transition to DECODE.
